// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: fetch/hazard-to-decode handshake and control bundle bus
// Ports (signals):
//   instr_valid, opcode, stall_in            driven by the fetch/hazard side (master)
//   ex_signals, mem_signals, wb_signals,
//   flush, illegal_op, busy                  driven by the control unit (slave)
interface pipelined_control_unit_if #(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 4
);
    logic               instr_valid;
    logic [OPC_W-1:0]   opcode;
    logic               stall_in;
    logic [ALUOP_W+1:0] ex_signals;
    logic [3:0]         mem_signals;
    logic [2:0]         wb_signals;
    logic               flush;
    logic               illegal_op;
    logic               busy;
    modport master (
        output instr_valid, opcode, stall_in,
        input  ex_signals, mem_signals, wb_signals, flush, illegal_op, busy
    );
    modport slave (
        input  instr_valid, opcode, stall_in,
        output ex_signals, mem_signals, wb_signals, flush, illegal_op, busy
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: registered ID-stage decoder producing EX/MEM/WB bundles
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of pipelined_control_unit_if:
//        instr_valid/opcode/stall_in in; ex_signals {alu_op, alu_en, shamt_sel},
//        mem_signals {mem_read, mem_write, mem_addr_sel, mem_data_sel},
//        wb_signals {reg_write, wb_sel[1:0]}, flush, illegal_op out (registered);
//        busy out (combinational from state)
module pipelined_control_unit #(
    parameter int OPC_W     = 6,
    parameter int ALUOP_W   = 4,
    parameter int IMM_WORDS = 1
) (
    input logic clk,
    input logic rst,
    pipelined_control_unit_if.slave bus
);
    typedef enum logic {S_DECODE, S_IMM} state_t;
    // Bits between the type field and the function field; must be zero for a legal opcode.
    localparam logic [OPC_W-1:0] MID_MASK =
        ~({OPC_W{1'b1}} << (OPC_W - 2)) & ({OPC_W{1'b1}} << ALUOP_W);
    state_t             state, state_n;
    logic [3:0]         imm_cnt, imm_n;
    logic [ALUOP_W+1:0] ex_q, ex_n;
    logic [3:0]         mem_q, mem_n;
    logic [2:0]         wb_q, wb_n;
    logic               flush_q, flush_n, ill_q, ill_n;
    logic [1:0]         typ;
    logic [ALUOP_W-1:0] fn;
    assign typ = bus.opcode[OPC_W-1 -: 2];
    assign fn  = bus.opcode[ALUOP_W-1:0];
    always_comb begin
        state_n = state;
        imm_n   = imm_cnt;
        ex_n    = '0;
        mem_n   = '0;
        wb_n    = '0;
        flush_n = 1'b0;
        ill_n   = 1'b0;
        // A stall freezes everything and emits a bubble; the word is re-presented later.
        if (!bus.stall_in && bus.instr_valid && state == S_DECODE) begin
            if ((bus.opcode & MID_MASK) != '0) ill_n = 1'b1;
            else case (typ)
                2'b00: begin
                    if (fn > ALUOP_W'(3)) ill_n = 1'b1;
                    else if (fn != '0) begin
                        ex_n = {fn, 1'b1, fn == ALUOP_W'(3)};
                        wb_n = 3'b101;
                    end
                end
                2'b01: begin
                    if (fn == ALUOP_W'(1)) begin
                        mem_n   = 4'b1000;
                        wb_n    = 3'b110;
                        flush_n = 1'b1;
                        state_n = S_IMM;
                        imm_n   = 4'(IMM_WORDS);
                    end else ill_n = 1'b1;
                end
                2'b10: begin
                    if (fn == ALUOP_W'(1)) begin
                        mem_n = 4'b1010;
                        wb_n  = 3'b100;
                    end else if (fn == ALUOP_W'(2)) mem_n = 4'b0110;
                    else ill_n = 1'b1;
                end
                default: ill_n = 1'b1;
            endcase
        end else if (!bus.stall_in && bus.instr_valid && state == S_IMM) begin
            // Immediate data words are consumed without decoding.
            imm_n   = imm_cnt - 4'd1;
            state_n = (imm_cnt == 4'd1) ? S_DECODE : S_IMM;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_DECODE;
            imm_cnt <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            flush_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state   <= state_n;
            imm_cnt <= imm_n;
            ex_q    <= ex_n;
            mem_q   <= mem_n;
            wb_q    <= wb_n;
            flush_q <= flush_n;
            ill_q   <= ill_n;
        end
    end
    assign bus.ex_signals  = ex_q;
    assign bus.mem_signals = mem_q;
    assign bus.wb_signals  = wb_q;
    assign bus.flush       = flush_q;
    assign bus.illegal_op  = ill_q;
    assign bus.busy        = (state != S_DECODE);
endmodule
